stream_distributor: RTL



---
 rtl/stream_distributor_if.sv | 28 ++
 rtl/stream_distributor.sv | 117 +++++++++++
 2 files changed

// File: rtl/stream_distributor_if.sv
// Stream bundle for stream_distributor: one input stb/ack stream, two output streams and
// per-output dispatch counts. 'master' is the distributor's view, 'slave' the environment's.
interface stream_distributor_if #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned COUNT_WIDTH = 16
);
  logic [WIDTH-1:0]       input_a;
  logic                   input_a_stb;
  logic                   input_a_ack;
  logic [WIDTH-1:0]       output_z;
  logic                   output_z_stb;
  logic                   output_z_ack;
  logic [WIDTH-1:0]       output_y;
  logic                   output_y_stb;
  logic                   output_y_ack;
  logic [COUNT_WIDTH-1:0] count_z;
  logic [COUNT_WIDTH-1:0] count_y;

  modport master (
    input  input_a, input_a_stb, output_z_ack, output_y_ack,
    output input_a_ack, output_z, output_z_stb, output_y, output_y_stb, count_z, count_y
  );

  modport slave (
    output input_a, input_a_stb, output_z_ack, output_y_ack,
    input  input_a_ack, output_z, output_z_stb, output_y, output_y_stb, count_z, count_y
  );
endinterface

// File: rtl/stream_distributor.sv
// Round-robin, work-conserving distributor of one stb/ack stream onto two output streams.
// One holding register feeds a one-word buffer per output; all outputs come from registers.
module stream_distributor #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  stream_distributor_if.master bus
);
  typedef enum logic {PtrZ = 1'b0, PtrY = 1'b1} ptr_e;

  logic                   r_in_ack, w_in_ack_d;
  logic                   r_hold_full, w_hold_full_d;
  logic [WIDTH-1:0]       r_hold_data, w_hold_data_d;
  logic                   r_z_full, w_z_full_d;
  logic [WIDTH-1:0]       r_z_data, w_z_data_d;
  logic                   r_y_full, w_y_full_d;
  logic [WIDTH-1:0]       r_y_data, w_y_data_d;
  ptr_e                   r_ptr, w_ptr_d;
  logic [COUNT_WIDTH-1:0] r_count_z, w_count_z_d;
  logic [COUNT_WIDTH-1:0] r_count_y, w_count_y_d;

  logic w_in_xfer, w_z_xfer, w_y_xfer, w_to_z, w_to_y;

  assign w_in_xfer = r_in_ack & bus.input_a_stb;
  assign w_z_xfer  = r_z_full & bus.output_z_ack;
  assign w_y_xfer  = r_y_full & bus.output_y_ack;

  always_comb begin
    w_to_z        = 1'b0;
    w_to_y        = 1'b0;
    w_hold_full_d = r_hold_full;
    w_hold_data_d = r_hold_data;
    w_z_full_d    = r_z_full;
    w_z_data_d    = r_z_data;
    w_y_full_d    = r_y_full;
    w_y_data_d    = r_y_data;
    w_ptr_d       = r_ptr;
    w_count_z_d   = r_count_z;
    w_count_y_d   = r_count_y;

    // Dispatch looks at buffer occupancy before this edge, so a buffer draining now
    // is only refilled on the following edge.
    if (r_hold_full) begin
      if (r_ptr == PtrZ) begin
        if (!r_z_full)      w_to_z = 1'b1;
        else if (!r_y_full) w_to_y = 1'b1;
      end else begin
        if (!r_y_full)      w_to_y = 1'b1;
        else if (!r_z_full) w_to_z = 1'b1;
      end
    end

    if (w_z_xfer) begin
      w_z_full_d  = 1'b0;
      w_count_z_d = r_count_z + COUNT_WIDTH'(1);
    end
    if (w_y_xfer) begin
      w_y_full_d  = 1'b0;
      w_count_y_d = r_count_y + COUNT_WIDTH'(1);
    end

    if (w_to_z) begin
      w_z_full_d = 1'b1;
      w_z_data_d = r_hold_data;
      w_ptr_d    = PtrY;
    end
    if (w_to_y) begin
      w_y_full_d = 1'b1;
      w_y_data_d = r_hold_data;
      w_ptr_d    = PtrZ;
    end

    if (w_to_z || w_to_y) w_hold_full_d = 1'b0;
    if (w_in_xfer) begin
      w_hold_full_d = 1'b1;
      w_hold_data_d = bus.input_a;
    end

    w_in_ack_d = ~w_hold_full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ack    <= 1'b0;
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_z_full    <= 1'b0;
      r_z_data    <= '0;
      r_y_full    <= 1'b0;
      r_y_data    <= '0;
      r_ptr       <= PtrZ;
      r_count_z   <= '0;
      r_count_y   <= '0;
    end else begin
      r_in_ack    <= w_in_ack_d;
      r_hold_full <= w_hold_full_d;
      r_hold_data <= w_hold_data_d;
      r_z_full    <= w_z_full_d;
      r_z_data    <= w_z_data_d;
      r_y_full    <= w_y_full_d;
      r_y_data    <= w_y_data_d;
      r_ptr       <= w_ptr_d;
      r_count_z   <= w_count_z_d;
      r_count_y   <= w_count_y_d;
    end
  end

  assign bus.input_a_ack  = r_in_ack;
  assign bus.output_z     = r_z_data;
  assign bus.output_z_stb = r_z_full;
  assign bus.output_y     = r_y_data;
  assign bus.output_y_stb = r_y_full;
  assign bus.count_z      = r_count_z;
  assign bus.count_y      = r_count_y;
endmodule
